// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI command sequencer.
// INIT_CMDS is replayed after reset only when SPI_SEQ_INIT_ROM_EN is defined.
package spi_seq_pkg;

  typedef logic [15:0] cmd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_BOOT  = 3'd4
  } seq_state_t;

  // Shared down-counter width for the transfer and gap timers.
  localparam int CNT_W = 16;

  localparam int INIT_LEN = 3;
  localparam int BIDX_W   = $clog2(INIT_LEN + 1);
  localparam cmd_word_t INIT_CMDS [INIT_LEN] = '{16'h0603, 16'h0927, 16'h0747};

  // Counter load value for a phase lasting 'cycles' cycles (terminal count at 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous command-word FIFO, DEPTH a power of 2.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module spi_cmd_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  logic [15:0] i_data,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output logic [15:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  cmd_word_t        r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; a reset flushes the queue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues host command words and feeds them to spi_master,
// one start pulse per word, with a fixed transfer window and idle gap.
// Optional macro SPI_SEQ_INIT_ROM_EN: replay INIT_CMDS after reset (BOOT).
//
// state | meaning
// IDLE  | waiting for a queued word; pops and raises spi_start when one exists
// START | spi_start high for exactly one cycle
// WAIT  | transfer window, down-counter from XFER_CYCLES-1 to 0
// GAP   | idle spacing, down-counter from GAP_CYCLES-1 to 0
// BOOT  | (macro only) issue the next INIT_CMDS word instead of a FIFO word
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int XFER_CYCLES = 34,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  output logic        spi_start,
  output logic [15:0] spi_data,
  output logic        busy,
  output logic        boot_done,
  output logic [7:0]  issued_count
);

  localparam logic [CNT_W-1:0] XFER_LOAD = cnt_load(XFER_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD  = cnt_load(GAP_CYCLES);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  seq_state_t       w_ret_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  cmd_word_t        r_spi_data;
  cmd_word_t        w_spi_data_nxt;
  logic             r_spi_start;
  logic             w_spi_start_nxt;
  logic [7:0]       r_issued;
  logic             w_issue_inc;
  logic             r_boot_done;
  logic             w_boot_done_nxt;
  logic             w_boot_finish;
  logic             w_xfer_end;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  cmd_word_t        w_head;
  logic             w_cmd_ready;

`ifdef SPI_SEQ_INIT_ROM_EN
  localparam seq_state_t RST_STATE     = ST_BOOT;
  localparam logic       RST_BOOT_DONE = 1'b0;

  logic [BIDX_W-1:0] r_boot_idx;
  logic              w_boot_issue;
  logic              w_boot_last;

  // Host words are held off until the boot list has fully drained.
  assign w_boot_last   = (r_boot_idx == BIDX_W'(INIT_LEN));
  assign w_ret_state   = (!r_boot_done && !w_boot_last) ? ST_BOOT : ST_IDLE;
  assign w_boot_finish = !r_boot_done && w_boot_last;
  assign w_cmd_ready   = !w_full && r_boot_done;
`else
  localparam seq_state_t RST_STATE     = ST_IDLE;
  localparam logic       RST_BOOT_DONE = 1'b1;

  assign w_ret_state   = ST_IDLE;
  assign w_boot_finish = 1'b0;
  assign w_cmd_ready   = !w_full;
`endif

  // Ready depends only on stored occupancy, never on a same-cycle pop.
  assign w_push = cmd_valid && w_cmd_ready;

  spi_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_data  (cmd_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Next-state and next-output decode for the issue/wait/gap sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_spi_data_nxt  = r_spi_data;
    w_spi_start_nxt = 1'b0;
    w_pop           = 1'b0;
    w_issue_inc     = 1'b0;
    w_xfer_end      = 1'b0;
    w_boot_done_nxt = r_boot_done;
`ifdef SPI_SEQ_INIT_ROM_EN
    w_boot_issue    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_spi_data_nxt  = w_head;
          w_spi_start_nxt = 1'b1;
          w_state_nxt     = ST_START;
        end
      end
      ST_START: begin
        w_issue_inc = 1'b1;
        w_cnt_nxt   = XFER_LOAD;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            w_xfer_end  = 1'b1;
            w_state_nxt = w_ret_state;
          end else begin
            w_cnt_nxt   = GAP_LOAD;
            w_state_nxt = ST_GAP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_xfer_end  = 1'b1;
          w_state_nxt = w_ret_state;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`ifdef SPI_SEQ_INIT_ROM_EN
      ST_BOOT: begin
        w_boot_issue    = 1'b1;
        w_spi_data_nxt  = INIT_CMDS[r_boot_idx];
        w_spi_start_nxt = 1'b1;
        w_state_nxt     = ST_START;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_xfer_end && w_boot_finish) w_boot_done_nxt = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= RST_STATE;
    else       r_state <= w_state_nxt;
  end

  // Registered outputs and the shared down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_spi_data  <= '0;
      r_spi_start <= 1'b0;
      r_issued    <= '0;
      r_boot_done <= RST_BOOT_DONE;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_spi_data  <= w_spi_data_nxt;
      r_spi_start <= w_spi_start_nxt;
      r_issued    <= r_issued + {7'd0, w_issue_inc};
      r_boot_done <= w_boot_done_nxt;
    end
  end

`ifdef SPI_SEQ_INIT_ROM_EN
  // Boot list position; advances as each ROM word is issued.
  always_ff @(posedge clk) begin
    if (reset)             r_boot_idx <= '0;
    else if (w_boot_issue) r_boot_idx <= r_boot_idx + 1'b1;
  end
`endif

  assign cmd_ready    = w_cmd_ready;
  assign spi_start    = r_spi_start;
  assign spi_data     = r_spi_data;
  assign busy         = (r_state != ST_IDLE) || !w_empty;
  assign boot_done    = r_boot_done;
  assign issued_count = r_issued;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: directed stimulus with a queue-based scoreboard.
// Pushed words enter exp_q; the negedge monitor pops one per spi_start.
module tb_spi_cmd_sequencer;

  localparam int XFER   = 34;
  localparam int GAP    = 2;
  localparam int DEPTH  = 4;
  localparam int PERIOD = XFER + GAP + 2;
`ifdef SPI_SEQ_INIT_ROM_EN
  localparam int BOOT_WORDS = 3;
  localparam bit MACRO_ON   = 1'b1;
`else
  localparam int BOOT_WORDS = 0;
  localparam bit MACRO_ON   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = 16'h0;
  logic        cmd_ready;
  logic        spi_start;
  logic [15:0] spi_data;
  logic        busy;
  logic        boot_done;
  logic [7:0]  issued_count;

  spi_cmd_sequencer #(
    .DEPTH       (DEPTH),
    .XFER_CYCLES (XFER),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .spi_start    (spi_start),
    .spi_data     (spi_data),
    .busy         (busy),
    .boot_done    (boot_done),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  exp_issued = 8'd0;
  int          n_starts = 0;
  int          last_start_cyc = 0;
  int          prev_start_cyc = 0;
  int          last_push_edge = 0;
  logic [15:0] held_data = 16'h0;
  logic        prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=%s (cyc %0d)", name, what, cyc);
  endtask

  // Monitor: every start pulse must carry the next expected word.
  always @(negedge clk) begin
    if (reset) begin
      held_data  = 16'h0;
      prev_start = 1'b0;
    end else begin
      if (spi_start) begin
        check("start_one_cycle", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) fail("unexpected_start", "start with empty scoreboard");
        else check("spi_data", {16'd0, spi_data}, {16'd0, exp_q.pop_front()});
        check("issued_at_start", {24'd0, issued_count}, {24'd0, exp_issued});
        exp_issued     = exp_issued + 8'd1;
        prev_start_cyc = last_start_cyc;
        last_start_cyc = cyc;
        n_starts++;
        held_data = spi_data;
      end else begin
        check("data_hold", {16'd0, spi_data}, {16'd0, held_data});
      end
      prev_start = spi_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (n_starts < n && t < 5000) begin
      step();
      t++;
    end
    if (n_starts < n) fail("start_timeout", "no start pulse");
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 20000) begin
      step();
      t++;
    end
    if (busy || exp_q.size() != 0) fail("idle_timeout", "still busy");
  endtask

  task automatic push(input logic [15:0] d);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && t < 300) begin
      step();
      t++;
    end
    if (!cmd_ready) begin
      fail("push_timeout", "cmd_ready stuck low");
    end else begin
      exp_q.push_back(d);
      last_push_edge = cyc + 1;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // Reset for one edge, check reset values, then let any boot replay finish.
  task automatic do_reset();
    int t = 0;
    int n0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    step();
    exp_q.delete();
    exp_issued = 8'd0;
    check("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_spi_data", {16'd0, spi_data}, 32'd0);
    check("rst_issued", {24'd0, issued_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, {31'd0, MACRO_ON});
    check("rst_boot_done", {31'd0, boot_done}, {31'd0, !MACRO_ON});
    check("rst_cmd_ready", {31'd0, cmd_ready}, {31'd0, !MACRO_ON});
    reset = 1'b0;
    n0 = n_starts;
`ifdef SPI_SEQ_INIT_ROM_EN
    for (int i = 0; i < spi_seq_pkg::INIT_LEN; i++) exp_q.push_back(spi_seq_pkg::INIT_CMDS[i]);
    while (!boot_done && t < 2000) begin
      check("boot_ready_low", {31'd0, cmd_ready}, 32'd0);
      step();
      t++;
    end
    if (!boot_done) fail("boot_timeout", "boot_done stuck low");
    check("boot_words", n_starts - n0, BOOT_WORDS);
    check("boot_spacing", last_start_cyc - prev_start_cyc, PERIOD);
    check("boot_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("boot_issued", {24'd0, issued_count}, BOOT_WORDS);
`else
    check("rst_no_start", n_starts - n0, 0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int s;
    repeat (3) step();
    do_reset();
    repeat (4) step();

`ifdef SPI_SEQ_INIT_ROM_EN
    n0 = n_starts;
    push(16'h1234);
    wait_starts(n0 + 1);
    wait_idle();
`endif

    // Single word: latency, pulse width, hold and busy timing.
    n0 = n_starts;
    push(16'h0404);
    wait_starts(n0 + 1);
    s = last_start_cyc;
    check("latency", s, last_push_edge + 1);
    wait_cyc(s + 1);
    check("start_low_after", {31'd0, spi_start}, 32'd0);
    check("issued_one", {24'd0, issued_count}, 8'(BOOT_WORDS + (MACRO_ON ? 2 : 1)));
    wait_cyc(s + 36);
    check("data_held_gap", {16'd0, spi_data}, 32'h0404);
    check("busy_in_gap", {31'd0, busy}, 32'd1);
    wait_cyc(s + 37);
    check("busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back pair.
    n0 = n_starts;
    push(16'h00FF);
    push(16'hAA55);
    wait_starts(n0 + 2);
    s = last_start_cyc;
    check("b2b_spacing", last_start_cyc - prev_start_cyc, PERIOD);
    wait_cyc(s + 36);
    check("b2b_busy_gap", {31'd0, busy}, 32'd1);
    wait_cyc(s + 37);
    check("b2b_busy_idle", {31'd0, busy}, 32'd0);

    // Fill the FIFO during an active transfer with cmd_valid held.
    n0 = n_starts;
    push(16'h1111);
    wait_starts(n0 + 1);
    for (int i = 0; i < 4; i++) push(16'hB000 + 16'(i));
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    push(16'hB004);
    push(16'hB005);
    wait_idle();
    check("six_all_issued", n_starts - n0, 7);
    check("six_spacing", last_start_cyc - prev_start_cyc, PERIOD);

    // Reset during WAIT of the second word with two words still queued.
    n0 = n_starts;
    push(16'hC001);
    push(16'hC002);
    push(16'hC003);
    push(16'hC004);
    wait_starts(n0 + 2);
    repeat (10) step();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    do_reset();
`ifndef SPI_SEQ_INIT_ROM_EN
    n0 = n_starts;
    repeat (100) step();
    check("no_start_after_reset", n_starts - n0, 0);
`endif

    // 257 words: issued_count wraps.
    n0 = n_starts;
    for (int i = 0; i < 257; i++) push(16'(i * 3 + 7));
    wait_idle();
    check("wrap_starts", n_starts - n0, 257);
    check("issued_wrap", {24'd0, issued_count}, 8'(BOOT_WORDS + 257));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Upstream feeder for spi_master in the HR monitor sensor path.
- Buffers 16-bit sensor command words from the control logic in a small FIFO.
- Presents each word on spi_data and pulses spi_start for one cycle.
- spi_master has no done output, so the sequencer waits a fixed transfer time before issuing the next word.

Parameters:
- DEPTH, 4: FIFO depth in words. Must be a power of 2 and at least 2.
- XFER_CYCLES, 34: clk cycles reserved per SPI transfer. Covers 16 bits at 2 clk per SCLK period, plus margin. Must be at least 1.
- GAP_CYCLES, 2: idle cycles inserted after each transfer. 0 is legal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host presents a command word
- cmd_data  in  16  command word
- cmd_ready  out  1  FIFO can accept a word
- spi_start  out  1  one-cycle start pulse to spi_master
- spi_data  out  16  word for spi_master data_in
- busy  out  1  transfer in progress or FIFO non-empty
- boot_done  out  1  boot sequence complete
- issued_count  out  8  number of start pulses issued, wraps

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: all outputs registered. After reset, spi_start=0, spi_data=16'h0000, issued_count=0, busy=0, FIFO empty, state=IDLE (BOOT if INIT_ROM_EN). cmd_ready=1 in IDLE without the macro.
- Handshake: a word is accepted on any edge with cmd_valid && cmd_ready.
  - cmd_ready = !full. It does not depend on a same-cycle pop, so a full FIFO never accepts, even while popping.
  - cmd_data is ignored when cmd_ready=0.
- FSM states: IDLE, START, WAIT, GAP (plus BOOT with the macro).
  - IDLE: if the FIFO is non-empty, pop the head into spi_data, set spi_start<=1, go to START. Otherwise stay.
  - START: lasts 1 cycle with spi_start=1. Then spi_start<=0, load counter=XFER_CYCLES-1, go to WAIT. issued_count increments on exit.
  - WAIT: decrement the counter. At 0, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: lasts GAP_CYCLES cycles, then go to IDLE.
- spi_data is held stable from the START cycle until the next pop. It is never changed during WAIT or GAP.
- Latency: a word accepted at edge E0 into an empty, idle block gives spi_start high in the cycle after E0+1.
- Back-to-back: with a FIFO backlog, consecutive spi_start rising edges are exactly XFER_CYCLES+GAP_CYCLES+2 cycles apart.
- busy = (state!=IDLE) || !empty.
- issued_count wraps from 255 to 0.
- Reset mid-transfer: at the next edge, the FSM goes to IDLE (or BOOT), the FIFO is flushed, spi_start=0, and spi_data=0. A partially shifted word in spi_master is abandoned.
- Pointer wrap: FIFO pointers are log2(DEPTH) bits plus 1 wrap bit. Full when the indexes are equal and the wrap bits differ.

Optional Feature:
- Macro: SPI_SEQ_INIT_ROM_EN.
- Defined: after reset, the FSM enters BOOT. It issues the INIT_LEN words of the package constant INIT_CMDS in order, with identical START/WAIT/GAP timing.
  - cmd_ready=0 during BOOT. Host writes are not accepted.
  - boot_done goes to 1 after the last word's GAP (or WAIT if GAP_CYCLES=0). The FSM then enters IDLE.
  - issued_count counts boot words.
- Undefined: no BOOT state, and boot_done=1 from the first cycle after reset.

Decomposition:
- Package spi_seq_pkg holds:
  - the state enum typedef
  - the cmd_word_t 16-bit typedef
  - INIT_LEN=3
  - INIT_CMDS = {16'h0603, 16'h0927, 16'h0747}
- Sub-module spi_cmd_fifo: synchronous FIFO with push, pop, full, empty and head output, parameterised on DEPTH.

Test Plan (XFER_CYCLES=34, GAP_CYCLES=2, DEPTH=4, macro off unless stated):
- Reset, then push 16'h0404 at edge 10 -> spi_start high only in the cycle after edge 11, spi_data=16'h0404 through edge 47, issued_count=1.
- Push 16'h00FF and 16'hAA55 back-to-back -> start pulses 38 cycles apart, spi_data 16'h00FF then 16'hAA55, busy low after the second GAP.
- Hold cmd_valid high with 6 words while a transfer is active -> cmd_ready drops after the 4th queued word and no word is lost. All 6 are issued in push order.
- Assert reset during WAIT of word 2 with 2 words queued -> next edge gives spi_start=0, spi_data=0, busy=0, no further start pulses.
- Issue 257 words -> issued_count reads 1 (wrapped).
- SPI_SEQ_INIT_ROM_EN defined -> after reset, 16'h0603, 16'h0927, 16'h0747 are issued 38 cycles apart, cmd_ready=0 until boot_done=1, then a host word 16'h1234 is issued next.
